latch_test_monitor: RTL and testbench
=====================================

// Module: latch_test_monitor
// PURPOSE
// - Downstream observer for the latch/flop test cell array: consumes its 8 output bits and records toggle activity.
// - Synchronises the observed bits into clk and counts toggles per bit with saturating counters.
// - Records the first-change mask and timestamp after arming.
// - Exposes all results through a registered 8-bit readout mux, so the results can be read one byte at a time over the pin-limited io_out bus.
// PARAMETERS
// - SYNC_STAGES  2  synchroniser depth on obs_i, range 2..3
// - CNT_W        8  per-bit toggle counter width, range 1..8; zero-extended on readout
// - TS_W         8  first-change timestamp width, range 1..8; zero-extended on readout
// PORTS
// - clk      in   1  single clock; every flop in the block uses it (top maps it from io_in[0])
// - rst_n    in   1  asynchronous, active-low reset (top maps it from io_in[1])
// - obs_i    in   8  observed outputs of the latch test cells; asynchronous to clk
// - arm_i    in   1  level: 1 = capture enabled, 0 = stop
// - clear_i  in   1  synchronous clear of all results; priority over arm_i
// - sel_i    in   4  readout select
// - rd_o     out  8  registered readout data
// - trig_o   out  1  first change has been captured (state RUN or HOLD)
// - busy_o   out  1  state is ARMED or RUN
// BEHAVIOUR
// - Reset: state=IDLE; sync chain, prev, counters, trig_mask, trig_ts, ts and rd_o all 0; trig_o=0; busy_o=0.
// - Change detection:
//   - s = last synchroniser stage; prev <= s on every cycle, in every state.
//   - chg = s ^ prev.
// - Counting:
//   - cnt_en = (state==ARMED | state==RUN) & arm_i & ~clear_i.
//   - When cnt_en, each counter with chg[i]=1 increments and saturates at all-ones.
// - Latency:
//   - obs_i sampled at edge N -> counter updates at edge N+SYNC_STAGES.
//   - rd_o reflects that update one edge later.
// - State transitions, evaluated per cycle; clear_i is checked first in every state:
//   - clear_i=1 (any state): zero counters, trig_mask and trig_ts; go IDLE.
//   - IDLE:   arm_i=1 -> ARMED with ts<=0. Otherwise hold.
//   - ARMED:  ts increments, saturating at all-ones.
//     - arm_i=0 -> IDLE; no capture.
//     - else if chg!=0 -> RUN; trig_mask<=chg; trig_ts<=ts; counters update in the same edge.
//   - RUN:    arm_i=0 -> HOLD; changes in that cycle are not counted.
//   - HOLD:   all results frozen. arm_i=1 -> ARMED with ts<=0; counters keep their values (accumulate).
// - Readout by sel_i, registered, rd_o valid 1 cycle after sel_i:
//   - 0..7 -> counter[sel_i]
//   - 8    -> trig_mask
//   - 9    -> trig_ts
//   - 10   -> s
//   - 11   -> {4'b0, trig_o, busy_o, state[1:0]}
//   - 12..15 -> 8'h00
// - State encoding: IDLE=0, ARMED=1, RUN=2, HOLD=3.
// - Boundary cases:
//   - A change on the same cycle arm_i rises in IDLE is not counted.
//   - Simultaneous clear_i=1 and arm_i=1 -> IDLE.
//   - Counters never wrap; ts never wraps.
// CONFIGURATION
// - LATCH_MON_DEGLITCH_EN defined:
//   - An extra register after s; a bit is accepted only when s matches that register on 2 consecutive samples.
//   - chg is computed on the accepted value.
//   - Latency +1 cycle.
//   - Single-cycle pulses on obs_i (e.g. edge-detector output) are dropped.
// - LATCH_MON_DEGLITCH_EN undefined: behaviour exactly as above; every synchronised toggle counts.
// STRUCTURE
// - Package latch_mon_pkg:
//   - state typedef (IDLE/ARMED/RUN/HOLD).
//   - readout select constants SEL_CNT0..SEL_CNT7, SEL_MASK, SEL_TS, SEL_LIVE, SEL_STAT.
// - Sub-module latch_mon_sat_ctr: inputs W, inc, clr; output cnt; saturating up-counter.
//   - Instantiated 8x for the per-bit counters, 1x for ts.
// - Synchroniser, FSM and readout mux stay in the top.
// TESTING
// 1. Reset with obs_i=8'hA5, no arm -> all counters 0; sel=10 gives 8'hA5 after SYNC_STAGES+1 cycles; sel=11 gives 8'h00.
// 2. Arm; after 5 cycles toggle obs_i[3] -> sel=8 gives 8'h08; sel=9 gives ts (==5+SYNC_STAGES-1); trig_o=1.
// 3. In RUN toggle obs_i[0] 300 times (CNT_W=8) -> counter0 reads 8'hFF, not wrapped.
// 4. Drop arm_i, toggle obs_i -> HOLD; counters unchanged; busy_o=0; re-arm -> counts accumulate.
// 5. clear_i=1 together with arm_i=1 in RUN -> IDLE; sel 0..9 all read 8'h00.
// 6. Apply a 1-cycle pulse on obs_i[7] -> counter7 +2 without LATCH_MON_DEGLITCH_EN; unchanged with it.
//    Assert rst_n low mid-RUN -> all outputs 0 immediately.

Source files
------------

// File: rtl/latch_mon_pkg.sv
// Shared types and constants for the latch test monitor.
// Optional build macro used by the monitor: LATCH_MON_DEGLITCH_EN.
package latch_mon_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        HOLD  = 2'd3
    } mon_state_t;

    localparam logic [3:0] SEL_CNT0 = 4'd0;
    localparam logic [3:0] SEL_CNT1 = 4'd1;
    localparam logic [3:0] SEL_CNT2 = 4'd2;
    localparam logic [3:0] SEL_CNT3 = 4'd3;
    localparam logic [3:0] SEL_CNT4 = 4'd4;
    localparam logic [3:0] SEL_CNT5 = 4'd5;
    localparam logic [3:0] SEL_CNT6 = 4'd6;
    localparam logic [3:0] SEL_CNT7 = 4'd7;
    localparam logic [3:0] SEL_MASK = 4'd8;
    localparam logic [3:0] SEL_TS   = 4'd9;
    localparam logic [3:0] SEL_LIVE = 4'd10;
    localparam logic [3:0] SEL_STAT = 4'd11;

    // Packs the status readout byte: {4'b0, trig, busy, state}
    function automatic logic [7:0] status_byte(input logic trig, input logic busy,
                                               input mon_state_t st);
        return {4'b0000, trig, busy, st};
    endfunction

endpackage

// File: rtl/latch_mon_sat_ctr.sv
// Saturating up-counter with synchronous clear; used for the per-bit toggle
// counters and for the post-arm timestamp.
module latch_mon_sat_ctr #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    // Count up on inc, stick at all-ones, clear has priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/latch_test_monitor.sv
// Observer for the latch/flop test cell array: synchronises the 8 observed
// bits, counts toggles per bit, captures the first change after arming and
// serves all results through a registered byte-wide readout mux.
// Build macro LATCH_MON_DEGLITCH_EN adds a two-sample acceptance filter that
// drops single-cycle pulses at the cost of one extra cycle of latency.
module latch_test_monitor
    import latch_mon_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8,
    parameter int TS_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] obs_i,
    input  logic       arm_i,
    input  logic       clear_i,
    input  logic [3:0] sel_i,
    output logic [7:0] rd_o,
    output logic       trig_o,
    output logic       busy_o
);

    logic [7:0]       sync_q [SYNC_STAGES];
    logic [7:0]       s;
    logic [7:0]       val;
    logic [7:0]       prev;
    logic [7:0]       chg;
    mon_state_t       state;
    logic [CNT_W-1:0] cnt [8];
    logic [TS_W-1:0]  ts;
    logic [TS_W-1:0]  trig_ts;
    logic [7:0]       trig_mask;
    logic [7:0]       rd_next;
    logic             cnt_en;
    logic             ts_inc;
    logic             ts_clr;

    // Multi-stage synchroniser bringing the asynchronous observed bits into clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= obs_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

`ifdef LATCH_MON_DEGLITCH_EN
    logic [7:0] dg;

    // Second sample of s; a bit is accepted only once two samples agree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dg <= '0;
        end else begin
            dg <= s;
        end
    end

    assign val = ((s ~^ dg) & s) | ((s ^ dg) & prev);
`else
    assign val = s;
`endif

    // Previous accepted value, tracked in every state so stale edges never count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= '0;
        end else begin
            prev <= val;
        end
    end

    assign chg    = val ^ prev;
    assign cnt_en = ((state == ARMED) || (state == RUN)) && arm_i && !clear_i;
    assign ts_inc = (state == ARMED) && !clear_i;
    assign ts_clr = clear_i || (((state == IDLE) || (state == HOLD)) && arm_i);

    for (genvar g = 0; g < 8; g++) begin : g_bit_ctr
        latch_mon_sat_ctr #(.W(CNT_W)) u_ctr (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (cnt_en && chg[g]),
            .clr   (clear_i),
            .cnt   (cnt[g])
        );
    end

    latch_mon_sat_ctr #(.W(TS_W)) u_ts (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ts_inc),
        .clr   (ts_clr),
        .cnt   (ts)
    );

    // Capture FSM: arm, catch the first change, hold results when disarmed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            trig_mask <= '0;
            trig_ts   <= '0;
        end else if (clear_i) begin
            state     <= IDLE;
            trig_mask <= '0;
            trig_ts   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arm_i) begin
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    if (!arm_i) begin
                        state <= IDLE;
                    end else if (chg != 8'h00) begin
                        state     <= RUN;
                        trig_mask <= chg;
                        trig_ts   <= ts;
                    end
                end
                RUN: begin
                    if (!arm_i) begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (arm_i) begin
                        state <= ARMED;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign trig_o = (state == RUN) || (state == HOLD);
    assign busy_o = (state == ARMED) || (state == RUN);

    // Readout selection, narrower fields zero-extended to a byte
    always_comb begin
        rd_next = '0;
        if (sel_i <= SEL_CNT7) begin
            rd_next[CNT_W-1:0] = cnt[sel_i[2:0]];
        end else begin
            case (sel_i)
                SEL_MASK: rd_next = trig_mask;
                SEL_TS:   rd_next[TS_W-1:0] = trig_ts;
                SEL_LIVE: rd_next = s;
                SEL_STAT: rd_next = status_byte(trig_o, busy_o, state);
                default:  rd_next = '0;
            endcase
        end
    end

    // Register the readout byte so the pin bus sees a clean value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_o <= '0;
        end else begin
            rd_o <= rd_next;
        end
    end

endmodule

// File: tb/tb_latch_test_monitor.sv
// Directed self-checking bench for latch_test_monitor.
// Honours LATCH_MON_DEGLITCH_EN in the same way as the design.
module tb_latch_test_monitor;

    localparam int SYNC  = 2;
    localparam int CNTW  = 8;
    localparam int TSW   = 8;
`ifdef LATCH_MON_DEGLITCH_EN
    localparam int DG = 1;
`else
    localparam int DG = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic [7:0] obs_i;
    logic       arm_i;
    logic       clear_i;
    logic [3:0] sel_i;
    logic [7:0] rd_o;
    logic       trig_o;
    logic       busy_o;

    int errors;
    int checks;

    latch_test_monitor #(
        .SYNC_STAGES (SYNC),
        .CNT_W       (CNTW),
        .TS_W        (TSW)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .obs_i   (obs_i),
        .arm_i   (arm_i),
        .clear_i (clear_i),
        .sel_i   (sel_i),
        .rd_o    (rd_o),
        .trig_o  (trig_o),
        .busy_o  (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Select a readout source and fetch the registered byte one edge later
    task automatic read_sel(input logic [3:0] sel, output logic [7:0] val);
        sel_i = sel;
        @(negedge clk);
        val = rd_o;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst_n   = 1'b0;
        obs_i   = 8'hA5;
        arm_i   = 1'b0;
        clear_i = 1'b0;
        sel_i   = 4'd10;
        repeat (2) @(negedge clk);
        checks++;
        if (rd_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd: got %h want %h", rd_o, 8'h00); end
        checks++;
        if (trig_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_trig: got %b want 0", trig_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
        rst_n = 1'b1;
        repeat (SYNC) @(negedge clk);
        checks++;
        if (rd_o !== 8'h00) begin errors++; $display("[TB] FAIL live_early: got %h want %h", rd_o, 8'h00); end
        @(negedge clk);
        checks++;
        if (rd_o !== 8'hA5) begin errors++; $display("[TB] FAIL live_a5: got %h want %h", rd_o, 8'hA5); end
        read_sel(4'd11, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("[TB] FAIL idle_status: got %h want %h", v, 8'h00); end
        for (int i = 0; i < 8; i++) begin
            read_sel(4'(i), v);
            checks++;
            if (v !== 8'h00) begin errors++; $display("[TB] FAIL reset_cnt%0d: got %h want %h", i, v, 8'h00); end
        end
    endtask

    task automatic test_first_change();
        logic [7:0] v;
        logic [7:0] exp_ts;
        exp_ts = 8'(5 + SYNC - 1 + DG);
        arm_i = 1'b1;
        repeat (5) @(negedge clk);
        obs_i[3] = ~obs_i[3];
        repeat (SYNC + DG) @(negedge clk);
        checks++;
        if (trig_o !== 1'b0) begin errors++; $display("[TB] FAIL trig_early: got %b want 0", trig_o); end
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL armed_busy: got %b want 1", busy_o); end
        @(negedge clk);
        checks++;
        if (trig_o !== 1'b1) begin errors++; $display("[TB] FAIL trig_set: got %b want 1", trig_o); end
        read_sel(4'd8, v);
        checks++;
        if (v !== 8'h08) begin errors++; $display("[TB] FAIL first_mask: got %h want %h", v, 8'h08); end
        read_sel(4'd9, v);
        checks++;
        if (v !== exp_ts) begin errors++; $display("[TB] FAIL first_ts: got %h want %h", v, exp_ts); end
        read_sel(4'd3, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("[TB] FAIL first_cnt3: got %h want %h", v, 8'h01); end
        read_sel(4'd11, v);
        checks++;
        if (v !== 8'h0E) begin errors++; $display("[TB] FAIL run_status: got %h want %h", v, 8'h0E); end
    endtask

    task automatic test_saturation();
        logic [7:0] v;
        for (int i = 0; i < 300; i++) begin
            obs_i[0] = ~obs_i[0];
            repeat (2) @(negedge clk);
        end
        repeat (6) @(negedge clk);
        read_sel(4'd0, v);
        checks++;
        if (v !== 8'hFF) begin errors++; $display("[TB] FAIL sat_cnt0: got %h want %h", v, 8'hFF); end
        read_sel(4'd3, v);
        checks++;
        if (v !== 8'h01) begin errors++; $display("[TB] FAIL sat_cnt3: got %h want %h", v, 8'h01); end
    endtask

    task automatic test_hold_rearm();
        logic [7:0] v;
        logic [7:0] exp_ts;
        exp_ts = 8'(3 + SYNC - 1 + DG);
        arm_i    = 1'b0;
        obs_i[1] = ~obs_i[1];
        repeat (6) @(negedge clk);
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL hold_busy: got %b want 0", busy_o); end
        checks++;
        if (trig_o !== 1'b1) begin errors++; $display("[TB] FAIL hold_trig: got %b want 1", trig_o); end
        read_sel(4'd1, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("[TB] FAIL hold_cnt1: got %h want %h", v, 8'h00); end
        read_sel(4'd0, v);
        checks++;
        if (v !== 8'hFF) begin errors++; $display("[TB] FAIL hold_cnt0: got %h want %h", v, 8'hFF); end
        read_sel(4'd11, v);
        checks++;
        if (v !== 8'h0B) begin errors++; $display("[TB] FAIL hold_status: got %h want %h", v, 8'h0B); end
        arm_i = 1'b1;
        repeat (3) @(negedge clk);
        obs_i[3] = ~obs_i[3];
        repeat (6) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL rearm_busy: got %b want 1", busy_o); end
        read_sel(4'd3, v);
        checks++;
        if (v !== 8'h02) begin errors++; $display("[TB] FAIL rearm_cnt3: got %h want %h", v, 8'h02); end
        read_sel(4'd9, v);
        checks++;
        if (v !== exp_ts) begin errors++; $display("[TB] FAIL rearm_ts: got %h want %h", v, exp_ts); end
        read_sel(4'd0, v);
        checks++;
        if (v !== 8'hFF) begin errors++; $display("[TB] FAIL rearm_cnt0: got %h want %h", v, 8'hFF); end
    endtask

    task automatic test_clear();
        logic [7:0] v;
        clear_i = 1'b1;
        arm_i   = 1'b1;
        sel_i   = 4'd11;
        @(negedge clk);
        clear_i = 1'b0;
        arm_i   = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL clear_busy: got %b want 0", busy_o); end
        checks++;
        if (trig_o !== 1'b0) begin errors++; $display("[TB] FAIL clear_trig: got %b want 0", trig_o); end
        @(negedge clk);
        checks++;
        if (rd_o !== 8'h00) begin errors++; $display("[TB] FAIL clear_status: got %h want %h", rd_o, 8'h00); end
        for (int i = 0; i < 10; i++) begin
            read_sel(4'(i), v);
            checks++;
            if (v !== 8'h00) begin errors++; $display("[TB] FAIL clear_sel%0d: got %h want %h", i, v, 8'h00); end
        end
    endtask

    task automatic test_pulse_and_reset();
        logic [7:0] v;
        logic [7:0] exp_cnt7;
        logic [7:0] exp_mask;
        exp_cnt7 = (DG != 0) ? 8'h00 : 8'h02;
        exp_mask = (DG != 0) ? 8'h04 : 8'h80;
        obs_i[5] = ~obs_i[5];
        repeat (SYNC + DG) @(negedge clk);
        arm_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (trig_o !== 1'b0) begin errors++; $display("[TB] FAIL armedge_trig: got %b want 0", trig_o); end
        read_sel(4'd5, v);
        checks++;
        if (v !== 8'h00) begin errors++; $display("[TB] FAIL armedge_cnt5: got %h want %h", v, 8'h00); end
        obs_i[7] = ~obs_i[7];
        @(negedge clk);
        obs_i[7] = ~obs_i[7];
        repeat (6) @(negedge clk);
        read_sel(4'd7, v);
        checks++;
        if (v !== exp_cnt7) begin errors++; $display("[TB] FAIL pulse_cnt7: got %h want %h", v, exp_cnt7); end
        obs_i[2] = ~obs_i[2];
        repeat (6) @(negedge clk);
        checks++;
        if (trig_o !== 1'b1) begin errors++; $display("[TB] FAIL pulse_trig: got %b want 1", trig_o); end
        read_sel(4'd8, v);
        checks++;
        if (v !== exp_mask) begin errors++; $display("[TB] FAIL pulse_mask: got %h want %h", v, exp_mask); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (rd_o !== 8'h00) begin errors++; $display("[TB] FAIL midrun_rd: got %h want %h", rd_o, 8'h00); end
        checks++;
        if (trig_o !== 1'b0) begin errors++; $display("[TB] FAIL midrun_trig: got %b want 0", trig_o); end
        checks++;
        if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrun_busy: got %b want 0", busy_o); end
        @(negedge clk);
        rst_n = 1'b1;
        arm_i = 1'b0;
    endtask

    // Scenario sequence
    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_first_change();
        test_saturation();
        test_hold_rearm();
        test_clear();
        test_pulse_and_reset();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
